wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 32-bit words per operand, legal range 2..16.
REQ-002 SHALL derive W = 32*NWORDS as the full operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port in_a, input, W bits: operand A.
REQ-008 SHALL have port in_b, input, W bits: operand B.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port out_sum, output, W bits: sum equal to (in_a + in_b + in_cin) mod 2^W.
REQ-013 SHALL have port out_cout, output, 1 bit: carry-out, bit W of the full sum.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-016 SHALL decode in_ready = (state==IDLE) and out_valid = (state==DONE) from state only, with no combinational path from in_valid or out_ready.
REQ-017 On an edge in IDLE with in_valid=1, SHALL register in_a, in_b and in_cin (cin into the carry register), set word index idx=0, and enter ADD.
REQ-018 In ADD, each edge SHALL feed word idx of A, word idx of B and the carry register to the 32-bit adder.
REQ-019 In ADD, each edge SHALL write the adder sum into word idx of the sum register, load the carry register with the adder cout, and increment idx.
REQ-020 On the ADD edge where idx==NWORDS-1, SHALL enter DONE and load out_cout from the final cout.
REQ-021 Latency: out_valid SHALL rise exactly NWORDS edges after the accepting edge (4 for the default).
REQ-022 Throughput: one transaction per NWORDS+2 cycles minimum.
REQ-023 In DONE, out_sum and out_cout SHALL be held stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-024 The block SHALL NOT accept a new operand in the same cycle a result is taken; in_ready rises the following cycle.
REQ-025 in_a, in_b, in_cin and in_valid SHALL be ignored while in_ready=0.
REQ-026 out_sum SHALL be defined only while out_valid=1; partial words are visible during ADD.
REQ-027 idx SHALL be sized ceil(log2(NWORDS)) bits and SHALL never exceed NWORDS-1.

Reset
REQ-028 On an edge with rst=1, state SHALL be set to IDLE, and idx, the carry register, the operand registers, out_sum and out_cout SHALL be set to 0.
REQ-029 Following reset, out_valid SHALL be 0, busy SHALL be 0, and in_ready SHALL be 1 from the first edge with rst high.
REQ-030 rst SHALL take priority over every other event, including the accept and result-taken edges.
REQ-031 Reset mid-ADD or mid-DONE SHALL abandon the transaction silently; no out_valid is ever produced for it.

Structure
REQ-032 Package wide_add_pkg SHALL hold WORD_W=32 and the state enum (IDLE, ADD, DONE).
REQ-033 SHALL instantiate exactly one combinational sub-module Brent_Kung (ports a, b, cin, s, cout), driven through the word-select mux.
REQ-034 SHALL contain no other arithmetic adders apart from the idx increment.

Verification (NWORDS=4)
REQ-035 Zero case: a=0, b=0, cin=0 -> out_sum=0, out_cout=0, out_valid exactly 4 edges after accept.
REQ-036 Full carry ripple: a=all-ones, b=1, cin=0 -> out_sum=0, out_cout=1, with the carry rippling through all 4 words.
REQ-037 Partial ripple: a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=0, cin=1 -> out_sum=0x00000001_00000000_00000000_00000000, out_cout=0.
REQ-038 Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 and new operands driven -> out_valid held, out_sum/out_cout stable, in_ready=0, new operands not captured; after out_ready=1, next accept one cycle later.
REQ-039 Reset mid-operation: rst pulsed on the 2nd ADD edge -> IDLE, out_valid never asserted; next transaction 0xAAAA...AAAA + 0x5555...5555, cin=1 -> out_sum=0, out_cout=1.
REQ-040 Random: 200 transactions with random out_ready stalls, each checked against a W+1-bit reference sum; zero mismatches and no lost or duplicated results.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared definitions for the word-serial wide adder.
//   WORD_W  : width of one adder slice; operands are processed one word per cycle.
//   state_t : control states of the sequencer.
package wide_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_seq_bk.sv
// Brent_Kung: 32-bit combinational adder with a Brent-Kung parallel prefix carry tree.
// Ports:
//   a, b : 32-bit addends
//   cin  : carry into bit 0
//   s    : 32-bit sum
//   cout : carry out of bit 31
module Brent_Kung
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  logic [WORD_W-1:0] pg_p;   // bitwise propagate, kept for the final xor
  logic [WORD_W-1:0] grp_g;  // group generate over [0..i] after both sweeps
  logic [WORD_W-1:0] grp_p;  // group propagate over [0..i] after both sweeps
  logic [WORD_W:0]   carry;

  always_comb begin
    pg_p  = a ^ b;
    grp_g = a & b;
    grp_p = a ^ b;

    // Up-sweep: indices 2d-1, 4d-1, ... absorb the span d below them.
    for (int d = 1; d < WORD_W; d = d * 2) begin
      for (int i = 2 * d - 1; i < WORD_W; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - d]);
        grp_p[i] = grp_p[i] & grp_p[i - d];
      end
    end

    // Down-sweep: fill the remaining positions from already-complete prefixes.
    for (int d = WORD_W / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WORD_W; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - d]);
        grp_p[i] = grp_p[i] & grp_p[i - d];
      end
    end

    // Carry-in folded in last: carry into bit i+1 is prefix [0..i] applied to cin.
    carry[0] = cin;
    for (int i = 0; i < WORD_W; i++) begin
      carry[i + 1] = grp_g[i] | (grp_p[i] & cin);
    end

    s    = pg_p ^ carry[WORD_W-1:0];
    cout = carry[WORD_W];
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: adds two NWORDS x 32-bit operands one word per cycle through a
// single 32-bit Brent_Kung slice, rippling the carry through a register.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout)
//   busy                : high whenever the sequencer is not IDLE
//   dbg_state           : current sequencer state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready and out_valid are decoded from the state register only, so
// neither depends combinationally on in_valid or out_ready. Operands are
// ignored whenever in_ready is 0; the result is held stable while out_valid is
// 1 and out_ready is 0. The edge that takes a result never accepts operands.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] in_a,
  input  logic [WORD_W*NWORDS-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy,
  output state_t                   dbg_state
);

  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q,     a_d;
  logic [W-1:0]      b_q,     b_d;
  logic [W-1:0]      sum_q,   sum_d;
  logic              cout_q,  cout_d;

  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  logic [WORD_W-1:0] bk_s;
  logic              bk_cout;

  // Word-select mux feeding the single adder slice.
  assign word_a = a_q[idx_q * WORD_W +: WORD_W];
  assign word_b = b_q[idx_q * WORD_W +: WORD_W];

  Brent_Kung u_bk (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_q),
    .s    (bk_s),
    .cout (bk_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q * WORD_W +: WORD_W] = bk_s;
        carry_d = bk_cout;
        if (idx_q == IDX_LAST) begin
          // Wrap idx to 0 rather than past NWORDS-1.
          idx_d   = '0;
          cout_d  = bk_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq with NWORDS=4: directed corner cases, reset
// abandonment, backpressure, then 200 random transactions against a plain
// (W+1)-bit arithmetic reference.
module tb_wide_add_seq;
  import wide_add_pkg::*;

  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
  state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected {cout, sum} pushed on accept, popped on result.
  logic [W:0] exp_q[$];

  wide_add_seq #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NWORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: the full sum with plain arithmetic, carry in bit W.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Driver: one full transaction. While busy, drives junk operands (and
  // random in_valid when junk=1) that must be ignored.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int stall, input bit junk);
    logic [W:0] exp;
    int lat;
    exp = ref_sum(a, b, cin);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = 1'b0;
    step();
    exp_q.push_back(exp);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      in_a     = rand_vec();
      in_b     = rand_vec();
      in_cin   = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    chk("latency", lat, NWORDS);
    if (exp_q.size() > 0) chk("result", {out_cout, out_sum}, exp_q.pop_front());
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_a     = rand_vec();
      in_b     = rand_vec();
      in_cin   = 1'($urandom_range(0, 1));
      step();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", {out_cout, out_sum}, exp);
    end
    out_ready = 1'b1;
    in_valid  = junk;
    in_a      = rand_vec();
    in_b      = rand_vec();
    step();
    chk("take_out_valid", out_valid, 0);
    chk("take_in_ready", in_ready, 1);
    chk("take_no_accept", busy, 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int seen_valid;

    ones      = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    // Reset state from the first edge with rst high.
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", {out_cout, out_sum}, '0);
    step();
    rst = 1'b0;

    // Zero case.
    run_txn('0, '0, 1'b0, 0, 1'b0);
    // Full carry ripple through every word.
    run_txn(ones, {{(W-1){1'b0}}, 1'b1}, 1'b0, 0, 1'b0);
    // Partial ripple through the lower three words.
    a = {32'h0, {3{32'hFFFF_FFFF}}};
    run_txn(a, '0, 1'b1, 1, 1'b0);
    chk("partial_ripple_const", ref_sum(a, '0, 1'b1),
        {1'b0, 32'h0000_0001, 96'h0});
    // Backpressure: 10 stall cycles with new operands offered.
    run_txn(rand_vec(), rand_vec(), 1'b1, 10, 1'b1);
    // Next accept comes straight after the take.
    run_txn(ones, ones, 1'b1, 0, 1'b0);

    // Reset on the second ADD edge abandons the transaction.
    in_valid = 1'b1;
    in_a     = rand_vec();
    in_b     = rand_vec();
    in_cin   = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", {out_cout, out_sum}, '0);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) seen_valid++;
    end
    chk("midrst_no_result", seen_valid, 0);
    run_txn({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b1, 2, 1'b0);

    // Random transactions with random stalls.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0:       begin a = ones;       b = rand_vec(); end
        1:       begin a = rand_vec(); b = ~a;         end
        default: begin a = rand_vec(); b = rand_vec(); end
      endcase
      run_txn(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
